// File: rtl/cp0_exc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// cp0_exc_ctrl : CP0 registers (SR/Cause/EPC/PRId) and exception/interrupt
//                entry, eret and pipeline flush/redirect control.
// Revision     : 1.0
// ---------------------------------------------------------------------------
module cp0_exc_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] PRID_VALUE   = 32'h4D49_5053,
  parameter logic [31:0] SR_RESET     = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] i_pc,
  input  logic        i_isInserted,
  input  logic        i_isBD,
  input  logic [4:0]  i_excCode,
  input  logic [5:0]  i_hwInt,
  input  logic        i_we,
  input  logic [4:0]  i_addr,
  input  logic [31:0] i_wdata,
  input  logic        i_eret,
  output logic [31:0] o_rdata,
  output logic [31:0] o_epc,
  output logic        o_flush,
  output logic        o_squashM,
  output logic        o_redirect,
  output logic [31:0] o_redirectPC
);

  localparam logic [31:0] c_sr_mask = 32'h0000_FC03;

  logic [31:0] sr_q, sr_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] epc_q, epc_d;

  logic        w_irq, w_exc, w_ret, w_entry, w_mtc0;
  logic [31:0] w_pc_adj;

  assign w_irq   = (|(cause_q[15:10] & sr_q[15:10])) & sr_q[0] & ~sr_q[1];
  assign w_exc   = (i_excCode != 5'd0) & ~i_isInserted & ~sr_q[1];
  assign w_ret   = i_eret & ~i_isInserted;
  assign w_entry = w_irq | w_exc;
  assign w_mtc0  = i_we & ~i_isInserted & ~w_entry & ~w_ret;

  // Delay-slot instructions restart at the branch so the branch re-executes.
  assign w_pc_adj = i_isBD ? (i_pc - 32'd4) : i_pc;

  always_comb begin
    sr_d         = sr_q;
    cause_d      = cause_q;
    epc_d        = epc_q;
    o_flush      = 1'b0;
    o_squashM    = 1'b0;
    o_redirect   = 1'b0;
    o_redirectPC = HANDLER_ADDR;

    cause_d[15:10] = i_hwInt;

    if (w_entry) begin
      o_flush       = 1'b1;
      o_squashM     = 1'b1;
      o_redirect    = 1'b1;
      o_redirectPC  = HANDLER_ADDR;
      sr_d[1]       = 1'b1;
      cause_d[6:2]  = w_irq ? 5'd0 : i_excCode;
      cause_d[31]   = i_isBD;
      epc_d         = {w_pc_adj[31:2], 2'b00};
    end else if (w_ret) begin
      o_flush      = 1'b1;
      o_redirect   = 1'b1;
      o_redirectPC = epc_q;
      sr_d[1]      = 1'b0;
    end else if (w_mtc0) begin
      case (i_addr)
        5'd12:   sr_d  = i_wdata & c_sr_mask;
        5'd14:   epc_d = {i_wdata[31:2], 2'b00};
        default: ;
      endcase
    end

    if (reset) begin
      sr_d       = SR_RESET & c_sr_mask;
      cause_d    = 32'd0;
      epc_d      = 32'd0;
      o_flush    = 1'b0;
      o_squashM  = 1'b0;
      o_redirect = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    sr_q    <= sr_d;
    cause_q <= cause_d;
    epc_q   <= epc_d;
  end

  always_comb begin
    o_rdata = 32'd0;
    case (i_addr)
      5'd12:   o_rdata = sr_q;
      5'd13:   o_rdata = cause_q;
      5'd14:   o_rdata = epc_q;
      5'd15:   o_rdata = PRID_VALUE;
      default: o_rdata = 32'd0;
    endcase
  end

  assign o_epc = epc_q;

endmodule
`default_nettype wire

// File: tb/tb_cp0_exc_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_cp0_exc_ctrl : vector table, reset sequence and randomized run against
//                   a field-level model of the CP0 exception controller.
// Revision        : 1.0
// ---------------------------------------------------------------------------
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] i_pc;
  logic        i_isInserted, i_isBD;
  logic [4:0]  i_excCode;
  logic [5:0]  i_hwInt;
  logic        i_we;
  logic [4:0]  i_addr;
  logic [31:0] i_wdata;
  logic        i_eret;
  logic [31:0] o_rdata, o_epc, o_redirectPC;
  logic        o_flush, o_squashM, o_redirect;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl dut (
    .clk(clk), .reset(reset), .i_pc(i_pc), .i_isInserted(i_isInserted),
    .i_isBD(i_isBD), .i_excCode(i_excCode), .i_hwInt(i_hwInt), .i_we(i_we),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_eret(i_eret), .o_rdata(o_rdata),
    .o_epc(o_epc), .o_flush(o_flush), .o_squashM(o_squashM),
    .o_redirect(o_redirect), .o_redirectPC(o_redirectPC)
  );

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic        eret;
    logic [31:0] pc;
    logic        ins;
    logic        bd;
    logic [4:0]  exc;
    logic [5:0]  hw;
    logic [2:0]  ctl;   // {flush, squashM, redirect}
    logic [31:0] rpc;
    logic [31:0] rdata;
    logic [31:0] epc;
  } vec_t;

  function automatic vec_t row(logic we, logic [4:0] addr, logic [31:0] wdata,
                               logic eret, logic [31:0] pc, logic ins, logic bd,
                               logic [4:0] exc, logic [5:0] hw, logic [2:0] ctl,
                               logic [31:0] rpc, logic [31:0] rdata, logic [31:0] epc);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.eret = eret; v.pc = pc;
    v.ins = ins; v.bd = bd; v.exc = exc; v.hw = hw; v.ctl = ctl;
    v.rpc = rpc; v.rdata = rdata; v.epc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    i_we = v.we; i_addr = v.addr; i_wdata = v.wdata; i_eret = v.eret;
    i_pc = v.pc; i_isInserted = v.ins; i_isBD = v.bd; i_excCode = v.exc;
    i_hwInt = v.hw;
  endtask

  // Reference model: architectural fields kept separately.
  logic       m_ie, m_exl, m_bd;
  logic [5:0] m_im, m_ip;
  logic [4:0] m_code;
  logic [31:0] m_epc;

  function automatic logic [31:0] m_sr();
    return {16'd0, m_im, 8'd0, m_exl, m_ie};
  endfunction

  function automatic logic [31:0] m_cause();
    return {m_bd, 15'd0, m_ip, 3'd0, m_code, 2'd0};
  endfunction

  task automatic m_reset();
    m_ie = 0; m_exl = 0; m_bd = 0; m_im = 0; m_ip = 0; m_code = 0; m_epc = 0;
  endtask

  // Checks current DUT outputs against the model, waits for the edge, then
  // advances the model with the same inputs.
  task automatic m_cycle(input vec_t v, input int n);
    logic        irq, exc, ret;
    logic [2:0]  ctl;
    logic [31:0] rpc, rd;
    irq = ((m_ip & m_im) != 0) && m_ie && !m_exl;
    exc = (v.exc != 0) && !v.ins && !m_exl;
    ret = v.eret && !v.ins;
    ctl = 3'b000; rpc = 32'h4180;
    if (irq || exc)  ctl = 3'b111;
    else if (ret) begin ctl = 3'b101; rpc = m_epc; end
    case (v.addr)
      5'd12:   rd = m_sr();
      5'd13:   rd = m_cause();
      5'd14:   rd = m_epc;
      5'd15:   rd = 32'h4D49_5053;
      default: rd = 0;
    endcase
    chk($sformatf("rnd%0d ctl", n), {29'd0, o_flush, o_squashM, o_redirect}, {29'd0, ctl});
    if (ctl[0]) chk($sformatf("rnd%0d rpc", n), o_redirectPC, rpc);
    chk($sformatf("rnd%0d rdata", n), o_rdata, rd);
    chk($sformatf("rnd%0d epc", n), o_epc, m_epc);
    @(posedge clk);
    if (irq || exc) begin
      m_exl  = 1;
      m_code = irq ? 5'd0 : v.exc;
      m_bd   = v.bd;
      m_epc  = (v.bd ? v.pc - 32'd4 : v.pc) & ~32'd3;
    end else if (ret) begin
      m_exl = 0;
    end else if (v.we && !v.ins) begin
      if (v.addr == 5'd12) begin
        m_im = v.wdata[15:10]; m_exl = v.wdata[1]; m_ie = v.wdata[0];
      end else if (v.addr == 5'd14) begin
        m_epc = v.wdata & ~32'd3;
      end
    end
    m_ip = v.hw;
  endtask

  vec_t tbl[31];
  vec_t idle;

  initial begin
    //          we addr   wdata          eret pc        ins bd exc    hw    ctl     rpc            rdata          epc
    tbl[0]  = row(0, 5'd12, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h0,         32'h0);
    tbl[1]  = row(0, 5'd13, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h0,         32'h0);
    tbl[2]  = row(0, 5'd14, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h0,         32'h0);
    tbl[3]  = row(0, 5'd15, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h4D49_5053, 32'h0);
    tbl[4]  = row(0, 5'd13, 32'h0,        0, 32'h3010, 0, 0, 5'd4,  6'd0, 3'b111, 32'h4180,     32'h0,         32'h0);
    tbl[5]  = row(0, 5'd14, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h3010,      32'h3010);
    tbl[6]  = row(0, 5'd13, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h10,        32'h3010);
    tbl[7]  = row(0, 5'd12, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h2,         32'h3010);
    tbl[8]  = row(0, 5'd12, 32'h0,        1, 32'h3100, 0, 0, 5'd0,  6'd0, 3'b101, 32'h3010,     32'h2,         32'h3010);
    tbl[9]  = row(0, 5'd12, 32'h0,        0, 32'h3024, 0, 1, 5'd10, 6'd0, 3'b111, 32'h4180,     32'h0,         32'h3010);
    tbl[10] = row(0, 5'd13, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h8000_0028, 32'h3020);
    tbl[11] = row(0, 5'd14, 32'h0,        1, 32'h0,    0, 0, 5'd0,  6'd0, 3'b101, 32'h3020,     32'h3020,      32'h3020);
    tbl[12] = row(1, 5'd12, 32'hFFFF_0401, 0, 32'h0,   0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h0,         32'h3020);
    tbl[13] = row(0, 5'd12, 32'h0,        0, 32'h3040, 1, 0, 5'd0,  6'd1, 3'b000, 32'h0,        32'h401,       32'h3020);
    tbl[14] = row(0, 5'd13, 32'h0,        0, 32'h3040, 1, 0, 5'd0,  6'd1, 3'b111, 32'h4180,     32'h8000_0428, 32'h3020);
    tbl[15] = row(0, 5'd13, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd1, 3'b000, 32'h0,        32'h400,       32'h3040);
    tbl[16] = row(0, 5'd12, 32'h0,        1, 32'h0,    0, 0, 5'd0,  6'd1, 3'b101, 32'h3040,     32'h403,       32'h3040);
    tbl[17] = row(0, 5'd14, 32'h0,        0, 32'h3050, 0, 0, 5'd0,  6'd1, 3'b111, 32'h4180,     32'h3040,      32'h3040);
    tbl[18] = row(0, 5'd12, 32'h0,        1, 32'h0,    0, 0, 5'd0,  6'd0, 3'b101, 32'h3050,     32'h403,       32'h3050);
    tbl[19] = row(1, 5'd14, 32'h5555,     0, 32'h3060, 0, 0, 5'd12, 6'd0, 3'b111, 32'h4180,     32'h3050,      32'h3050);
    tbl[20] = row(1, 5'd14, 32'h5555,     0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h3060,      32'h3060);
    tbl[21] = row(0, 5'd14, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h5554,      32'h5554);
    tbl[22] = row(1, 5'd13, 32'hFFFF_FFFF, 0, 32'h0,   0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h30,        32'h5554);
    tbl[23] = row(0, 5'd13, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h30,        32'h5554);
    tbl[24] = row(1, 5'd14, 32'h1234,     0, 32'h0,    1, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h5554,      32'h5554);
    tbl[25] = row(0, 5'd14, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h5554,      32'h5554);
    tbl[26] = row(0, 5'd14, 32'h0,        0, 32'h3070, 0, 0, 5'd5,  6'd0, 3'b000, 32'h0,        32'h5554,      32'h5554);
    tbl[27] = row(0, 5'd16, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h0,         32'h5554);
    tbl[28] = row(0, 5'd12, 32'h0,        1, 32'h0,    0, 0, 5'd0,  6'd0, 3'b101, 32'h5554,     32'h403,       32'h5554);
    tbl[29] = row(0, 5'd12, 32'h0,        0, 32'h3080, 1, 0, 5'd4,  6'd0, 3'b000, 32'h0,        32'h401,       32'h5554);
    tbl[30] = row(0, 5'd12, 32'h0,        1, 32'h3090, 1, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h401,       32'h5554);
    idle    = row(0, 5'd12, 32'h0,        0, 32'h0,    0, 0, 5'd0,  6'd0, 3'b000, 32'h0,        32'h0,         32'h0);

    // Reset held with an exception presented: no control output may assert.
    reset = 1'b1;
    drive(row(0, 5'd12, 32'h0, 0, 32'h3010, 0, 0, 5'd4, 6'd0, 3'b000, 0, 0, 0));
    repeat (2) begin
      @(negedge clk); #1;
      chk("reset ctl", {29'd0, o_flush, o_squashM, o_redirect}, 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 31; i++) begin
      drive(tbl[i]);
      #1;
      chk($sformatf("row%0d ctl", i), {29'd0, o_flush, o_squashM, o_redirect}, {29'd0, tbl[i].ctl});
      if (tbl[i].ctl[0]) chk($sformatf("row%0d rpc", i), o_redirectPC, tbl[i].rpc);
      chk($sformatf("row%0d rdata", i), o_rdata, tbl[i].rdata);
      chk($sformatf("row%0d epc", i), o_epc, tbl[i].epc);
      @(negedge clk);
    end

    // Mid-run reset with hwInt high: registers clear, IP refills one cycle later.
    drive(row(0, 5'd12, 32'h0, 0, 32'h30A0, 0, 0, 5'd7, 6'd1, 3'b000, 0, 0, 0));
    reset = 1'b1;
    #1 chk("midreset ctl", {29'd0, o_flush, o_squashM, o_redirect}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(row(0, 5'd12, 32'h0, 0, 32'h0, 0, 0, 5'd0, 6'd1, 3'b000, 0, 0, 0));
    #1 chk("post-reset sr", o_rdata, 32'd0);
    chk("post-reset epc", o_epc, 32'd0);
    @(negedge clk);
    i_addr = 5'd13;
    #1 chk("post-reset ip", o_rdata, 32'h400);
    @(negedge clk);

    // Randomized run against the model.
    reset = 1'b1;
    drive(idle);
    @(negedge clk);
    reset = 1'b0;
    m_reset();
    begin
      vec_t v;
      int   sel;
      v = idle;
      for (int n = 0; n < 2000; n++) begin
        @(negedge clk);
        v.we    = ($urandom % 4) == 0;
        sel     = $urandom % 6;
        v.addr  = (sel == 0) ? 5'd12 : (sel == 1) ? 5'd13 : (sel == 2) ? 5'd14 :
                  (sel == 3) ? 5'd15 : 5'($urandom);
        v.wdata = $urandom;
        v.eret  = ($urandom % 8) == 0;
        v.pc    = $urandom;
        v.ins   = ($urandom % 4) == 0;
        v.bd    = 1'($urandom);
        v.exc   = (($urandom % 3) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
        if (($urandom % 8) == 0) v.hw = 6'($urandom);
        drive(v);
        #1;
        m_cycle(v, n);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
